// File: rtl/pooled_output_packer.sv
// Packs pairs of signed 8-bit pooled results into 16-bit words (first result in
// the high byte) and writes them to consecutive output SRAM addresses.
module pooled_output_packer #(
    parameter int unsigned       ADDR_W    = 12,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        PAD_BYTE  = 8'h00
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    input  logic [1:0]        valid_in,
    input  logic [7:0]        data_in,
    output logic              output_sram_write_enable,
    output logic [ADDR_W-1:0] output_sram_write_addresss,
    output logic [DATA_W-1:0] output_sram_write_data,
    output logic              packer_busy,
    output logic              packer_done,
    output logic [ADDR_W-1:0] words_written,
    output logic              addr_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT_HI,
        S_COLLECT_LO,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [7:0]        hi_q, hi_d;

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (dut_run) state_d = S_COLLECT_HI;
            end
            S_COLLECT_HI: begin
                if (valid_in == 2'b01)      state_d = S_COLLECT_LO;
                else if (valid_in == 2'b10) state_d = S_FLUSH;
            end
            S_COLLECT_LO: begin
                if (valid_in[0])            state_d = S_COLLECT_HI;
                else if (valid_in == 2'b10) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        words_d    = words_q;
        ovf_d      = ovf_q;
        addr_cnt_d = addr_cnt_q;
        hi_d       = hi_q;
        busy_d     = (state_d == S_COLLECT_HI) || (state_d == S_COLLECT_LO) ||
                     (state_d == S_FLUSH);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (dut_run) begin
                    addr_cnt_d = BASE_ADDR;
                    words_d    = '0;
                    ovf_d      = 1'b0;
                end
            end
            S_COLLECT_HI: begin
                if (valid_in == 2'b01) begin
                    hi_d = data_in;
                end else if (valid_in == 2'b11) begin
                    we_d    = 1'b1;
                    wdata_d = {data_in, PAD_BYTE};
                end
            end
            S_COLLECT_LO: begin
                if (valid_in[0]) begin
                    we_d    = 1'b1;
                    wdata_d = {hi_q, data_in};
                end else if (valid_in == 2'b10) begin
                    we_d    = 1'b1;
                    wdata_d = {hi_q, PAD_BYTE};
                end
            end
            S_FLUSH: done_d = 1'b1;
            default: ;
        endcase
        // The presented address is the pre-increment counter value.
        if (we_d) begin
            waddr_d    = addr_cnt_q;
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
            words_d    = words_q + ADDR_W'(1);
            if (addr_cnt_q == '1) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
            addr_cnt_q <= BASE_ADDR;
            hi_q       <= '0;
        end else begin
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            addr_cnt_q <= addr_cnt_d;
            hi_q       <= hi_d;
        end
    end

    assign output_sram_write_enable   = we_q;
    assign output_sram_write_addresss = waddr_q;
    assign output_sram_write_data     = wdata_q;
    assign packer_busy                = busy_q;
    assign packer_done                = done_q;
    assign words_written              = words_q;
    assign addr_overflow              = ovf_q;

endmodule

// File: tb/tb_pooled_output_packer.sv
// Scoreboard bench: two packers (base 0x000 and base 0xFFF) share one stimulus stream.
module tb_pooled_output_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_b, dut_run;
    logic [1:0]  valid_in;
    logic [7:0]  data_in;

    logic        we_a, busy_a, done_a, ovf_a;
    logic [11:0] addr_a, words_a;
    logic [15:0] data_a;
    logic        we_b, busy_b, done_b, ovf_b;
    logic [11:0] addr_b, words_b;
    logic [15:0] data_b;

    pooled_output_packer #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'h000), .PAD_BYTE(8'h00)) dut_a (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .valid_in(valid_in), .data_in(data_in),
        .output_sram_write_enable(we_a), .output_sram_write_addresss(addr_a),
        .output_sram_write_data(data_a), .packer_busy(busy_a), .packer_done(done_a),
        .words_written(words_a), .addr_overflow(ovf_a)
    );

    pooled_output_packer #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'hFFF), .PAD_BYTE(8'h00)) dut_b (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .valid_in(valid_in), .data_in(data_in),
        .output_sram_write_enable(we_b), .output_sram_write_addresss(addr_b),
        .output_sram_write_data(data_b), .packer_busy(busy_b), .packer_done(done_b),
        .words_written(words_b), .addr_overflow(ovf_b)
    );

    typedef struct {
        logic [15:0] data;
        logic [11:0] addr;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [11:0] ea, eb;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_word(input logic [15:0] w);
        q_a.push_back('{data: w, addr: ea, cyc: cyc});
        q_b.push_back('{data: w, addr: eb, cyc: cyc});
        ea = ea + 12'd1;
        eb = eb + 12'd1;
    endtask

    task automatic send(input logic [1:0] code, input logic [7:0] d);
        valid_in = code;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in = 2'b00;
        data_in  = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run();
        valid_in = 2'b00;
        dut_run  = 1'b1;
        @(posedge clk);
        #1;
        dut_run = 1'b0;
        ea = 12'h000;
        eb = 12'hFFF;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we_a"},    32'(we_a),    32'd0);
        chk({tag, "_addr_a"},  32'(addr_a),  32'd0);
        chk({tag, "_data_a"},  32'(data_a),  32'd0);
        chk({tag, "_flags_a"}, 32'({busy_a, done_a, ovf_a}), 32'd0);
        chk({tag, "_words_a"}, 32'(words_a), 32'd0);
        chk({tag, "_we_b"},    32'(we_b),    32'd0);
        chk({tag, "_addr_b"},  32'(addr_b),  32'd0);
        chk({tag, "_flags_b"}, 32'({busy_b, done_b, ovf_b}), 32'd0);
    endtask

    always @(negedge clk) begin : monitor_a
        exp_t e;
        if (we_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write_a: got data 0x%0h addr 0x%0h, required no write (cycle %0d)",
                         data_a, addr_a, cyc);
            end else begin
                e = q_a.pop_front();
                chk("wdata_a", 32'(data_a), 32'(e.data));
                chk("waddr_a", 32'(addr_a), 32'(e.addr));
                chk("wcycle_a", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : monitor_b
        exp_t e;
        if (we_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write_b: got data 0x%0h addr 0x%0h, required no write (cycle %0d)",
                         data_b, addr_b, cyc);
            end else begin
                e = q_b.pop_front();
                chk("wdata_b", 32'(data_b), 32'(e.data));
                chk("waddr_b", 32'(addr_b), 32'(e.addr));
                chk("wcycle_b", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        reset_b  = 1'b1;
        dut_run  = 1'b0;
        valid_in = 2'b00;
        data_in  = 8'h00;
        ea       = 12'h000;
        eb       = 12'hFFF;
        idle(3);
        @(negedge clk);
        chk_zero("reset");
        reset_b = 1'b0;
        idle(1);

        // Even matrix, end-of-run, done timing
        run();
        @(negedge clk);
        chk("busy_after_run", 32'(busy_a), 32'd1);
        send(2'b01, 8'h12);
        send(2'b01, 8'h34); expect_word(16'h1234);
        send(2'b01, 8'h56);
        send(2'b11, 8'h78); expect_word(16'h5678);
        send(2'b10, 8'h00);
        valid_in = 2'b00;
        @(negedge clk);
        chk("done_early", 32'(done_a), 32'd0);
        idle(1);
        @(negedge clk);
        chk("done_pulse_a", 32'(done_a), 32'd1);
        chk("done_pulse_b", 32'(done_b), 32'd1);
        idle(1);
        @(negedge clk);
        chk("done_cleared", 32'(done_a), 32'd0);
        chk("busy_in_done", 32'(busy_a), 32'd0);
        chk("words_t1", 32'(words_a), 32'd2);
        chk("ovf_t1_a", 32'(ovf_a), 32'd0);
        chk("ovf_t1_b", 32'(ovf_b), 32'd1);

        // Data in DONE is dropped; counters held
        send(2'b01, 8'h99);
        send(2'b11, 8'h98);
        idle(2);
        @(negedge clk);
        chk("ovf_held_b", 32'(ovf_b), 32'd1);
        chk("words_held", 32'(words_a), 32'd2);

        // Restart from DONE; odd matrix then back-to-back matrices with a stray start pulse
        run();
        @(negedge clk);
        chk("words_cleared", 32'(words_a), 32'd0);
        chk("ovf_cleared_b", 32'(ovf_b), 32'd0);
        send(2'b01, 8'h0A);
        send(2'b01, 8'h0B); expect_word(16'h0A0B);
        send(2'b11, 8'h0C); expect_word(16'h0C00);
        send(2'b11, 8'h11); expect_word(16'h1100);
        dut_run = 1'b1;
        send(2'b01, 8'h22);
        dut_run = 1'b0;
        send(2'b11, 8'h33); expect_word(16'h2233);
        send(2'b10, 8'h00);
        idle(3);
        @(negedge clk);
        chk("words_t3", 32'(words_a), 32'd4);
        chk("ovf_t3_b", 32'(ovf_b), 32'd1);

        // End-of-run while a high byte is held
        run();
        send(2'b01, 8'h7F);
        send(2'b10, 8'h00); expect_word(16'h7F00);
        valid_in = 2'b00;
        @(negedge clk);
        chk("done_early_lo", 32'(done_a), 32'd0);
        idle(1);
        @(negedge clk);
        chk("done_pulse_lo", 32'(done_a), 32'd1);
        idle(1);
        @(negedge clk);
        chk("words_lo", 32'(words_a), 32'd1);

        // Reset while a byte is held: no partial write, restart at base
        run();
        send(2'b01, 8'hAA);
        valid_in = 2'b00;
        reset_b  = 1'b1;
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset");
        idle(2);
        send(2'b11, 8'h44);
        idle(2);
        run();
        send(2'b11, 8'h5E); expect_word(16'h5E00);
        send(2'b10, 8'h00);
        idle(3);
        @(negedge clk);
        chk("words_after_reset", 32'(words_a), 32'd1);
        chk("ovf_after_reset_b", 32'(ovf_b), 32'd1);

        idle(3);
        chk("pending_a", 32'(q_a.size()), 32'd0);
        chk("pending_b", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
